// File: rtl/mux4_serializer_ctrl.sv
// Sequencer for an external 4:1 bit-select mux: latches a 4-bit word, steps the
// mux select through all positions and streams the sampled bits over valid/ready/last.
module mux4_serializer_ctrl #(
  parameter bit          MSB_FIRST = 1'b0,
  parameter int unsigned GAP       = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] mux_d,
  output logic [1:0] mux_s,
  input  logic       mux_a,
  output logic       ser_valid,
  output logic       ser_bit,
  output logic       ser_last,
  input  logic       ser_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [1:0] FIRST_SEL = MSB_FIRST ? 2'd3 : 2'd0;
  localparam logic [3:0] GAP_LOAD  = 4'(GAP);

  state_t     state_q, state_d;
  logic [3:0] mux_d_q, mux_d_d;
  logic [1:0] mux_s_q, mux_s_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] gap_q, gap_d;
  logic       ser_valid_q, ser_valid_d;
  logic       ser_bit_q, ser_bit_d;
  logic       ser_last_q, ser_last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mux_d_q     <= '0;
      mux_s_q     <= '0;
      idx_q       <= '0;
      gap_q       <= '0;
      ser_valid_q <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mux_d_q     <= mux_d_d;
      mux_s_q     <= mux_s_d;
      idx_q       <= idx_d;
      gap_q       <= gap_d;
      ser_valid_q <= ser_valid_d;
      ser_bit_q   <= ser_bit_d;
      ser_last_q  <= ser_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mux_d_d     = mux_d_q;
    mux_s_d     = mux_s_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    ser_valid_d = ser_valid_q;
    ser_bit_d   = ser_bit_q;
    ser_last_d  = ser_last_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mux_d_d = in_data;
          mux_s_d = FIRST_SEL;
          idx_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // mux_d/mux_s have been stable for this whole cycle, so mux_a is settled
        ser_bit_d   = mux_a;
        ser_valid_d = 1'b1;
        ser_last_d  = (idx_q == 2'd3);
        state_d     = HOLD;
      end
      HOLD: begin
        if (ser_ready) begin
          ser_valid_d = 1'b0;
          ser_last_d  = 1'b0;
          if (idx_q == 2'd3) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 2'd1;
            mux_s_d = MSB_FIRST ? (mux_s_q - 2'd1) : (mux_s_q + 2'd1);
            if (GAP == 0) begin
              state_d = DRIVE;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        gap_d = gap_q - 4'd1;
        if (gap_q == 4'd1) begin
          state_d = DRIVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = !busy;
  assign mux_d     = mux_d_q;
  assign mux_s     = mux_s_q;
  assign ser_valid = ser_valid_q;
  assign ser_bit   = ser_bit_q;
  assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_mux4_serializer_ctrl.sv
// Scoreboard bench for mux4_serializer_ctrl: three instances (LSB-first, MSB-first,
// GAP=2) each driving a behavioural 4:1 mux; a monitor checks every handshaken bit.
module tb_mux4_serializer_ctrl;

  logic       clk = 1'b0;
  logic [2:0] rst_n;
  logic [2:0] in_valid;
  logic [3:0] in_data [3];
  logic [2:0] in_ready;
  logic [3:0] mux_d [3];
  logic [1:0] mux_s [3];
  logic [2:0] mux_a;
  logic [2:0] ser_valid;
  logic [2:0] ser_bit;
  logic [2:0] ser_last;
  logic [2:0] ser_ready;
  logic [2:0] busy;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  typedef struct {
    int         inst;
    bit         b;
    bit         last;
    logic [1:0] s;
    int         edge_exp;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  always_comb begin
    for (int i = 0; i < 3; i++) mux_a[i] = mux_d[i][mux_s[i]];
  end

  mux4_serializer_ctrl #(.MSB_FIRST(1'b0), .GAP(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .mux_d(mux_d[0]), .mux_s(mux_s[0]), .mux_a(mux_a[0]),
    .ser_valid(ser_valid[0]), .ser_bit(ser_bit[0]), .ser_last(ser_last[0]),
    .ser_ready(ser_ready[0]), .busy(busy[0]));

  mux4_serializer_ctrl #(.MSB_FIRST(1'b1), .GAP(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .mux_d(mux_d[1]), .mux_s(mux_s[1]), .mux_a(mux_a[1]),
    .ser_valid(ser_valid[1]), .ser_bit(ser_bit[1]), .ser_last(ser_last[1]),
    .ser_ready(ser_ready[1]), .busy(busy[1]));

  mux4_serializer_ctrl #(.MSB_FIRST(1'b0), .GAP(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .mux_d(mux_d[2]), .mux_s(mux_s[2]), .mux_a(mux_a[2]),
    .ser_valid(ser_valid[2]), .ser_bit(ser_bit[2]), .ser_last(ser_last[2]),
    .ser_ready(ser_ready[2]), .busy(busy[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // bits[k] / sels field k are the k-th emitted bit and its select; g<0 skips timing
  task automatic push_word(input int inst, input bit [0:3] bits, input logic [7:0] sels,
                           input int t0, input int g, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.inst     = inst;
      e.b        = bits[k];
      e.last     = (k == 3);
      e.s        = sels[7-2*k -: 2];
      e.edge_exp = (g < 0) ? -1 : t0 + 2 + (2 + g) * k;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst_n[i] && ser_valid[i] && ser_ready[i]) begin
        if (sb.size() == 0) begin
          chk("unexpected_bit", i, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("bit_inst", i, e.inst);
          chk("ser_bit", int'(ser_bit[i]), int'(e.b));
          chk("ser_last", int'(ser_last[i]), int'(e.last));
          chk("mux_s", int'(mux_s[i]), int'(e.s));
          if (e.edge_exp >= 0) chk("handshake_edge", edge_n + 1, e.edge_exp);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [3:0] d, output int t0);
    int n = 0;
    while (!in_ready[i] && n < 100) begin
      cyc(1);
      n++;
    end
    if (!in_ready[i]) chk("send_wait_ready", 0, 1);
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    cyc(1);
    t0 = edge_n;
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (!in_ready[i] && n < 200) begin
      cyc(1);
      n++;
    end
    chk("idle_reached", int'(in_ready[i]), 1);
    chk("all_bits_seen", sb.size(), 0);
  endtask

  task automatic chk_reset_vals(input int i);
    chk("rst_in_ready", int'(in_ready[i]), 1);
    chk("rst_busy", int'(busy[i]), 0);
    chk("rst_ser_valid", int'(ser_valid[i]), 0);
    chk("rst_ser_bit", int'(ser_bit[i]), 0);
    chk("rst_ser_last", int'(ser_last[i]), 0);
    chk("rst_mux_d", int'(mux_d[i]), 0);
    chk("rst_mux_s", int'(mux_s[i]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int t1;
    rst_n     = '0;
    in_valid  = '0;
    ser_ready = '1;
    for (int i = 0; i < 3; i++) in_data[i] = '0;
    cyc(3);
    for (int i = 0; i < 3; i++) chk_reset_vals(i);
    rst_n = '1;
    cyc(2);

    // LSB-first 0111: bits 1,1,1,0 on selects 0..3, in_ready back at E8
    send(0, 4'b0111, t0);
    push_word(0, 4'b1110, {2'd0, 2'd1, 2'd2, 2'd3}, t0, 0, 4);
    chk("t1_mux_d", int'(mux_d[0]), 4'b0111);
    chk("t1_busy", int'(busy[0]), 1);
    cyc(1);
    chk("t1_valid_E1", int'(ser_valid[0]), 1);
    cyc(6);
    chk("t1_in_ready_E7", int'(in_ready[0]), 0);
    cyc(1);
    chk("t1_in_ready_E8", int'(in_ready[0]), 1);
    chk("t1_busy_E8", int'(busy[0]), 0);
    wait_idle(0);

    // MSB-first 0111: bits 0,1,1,1 on selects 3,2,1,0
    send(1, 4'b0111, t0);
    push_word(1, 4'b0111, {2'd3, 2'd2, 2'd1, 2'd0}, t0, 0, 4);
    chk("t2_mux_s_first", int'(mux_s[1]), 3);
    wait_idle(1);

    // Backpressure on the second bit of 1010
    send(0, 4'b1010, t0);
    push_word(0, 4'b0101, {2'd0, 2'd1, 2'd2, 2'd3}, t0, -1, 4);
    cyc(2);
    ser_ready[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc(1);
      chk("bp_valid_held", int'(ser_valid[0]), 1);
      chk("bp_bit_held", int'(ser_bit[0]), 1);
      chk("bp_sel_held", int'(mux_s[0]), 1);
    end
    ser_ready[0] = 1'b1;
    cyc(1);
    chk("bp_released", int'(ser_valid[0]), 0);
    chk("bp_next_sel", int'(mux_s[0]), 2);
    wait_idle(0);

    // in_valid held with 1111 while 0000 is in flight
    send(0, 4'b0000, t0);
    push_word(0, 4'b0000, {2'd0, 2'd1, 2'd2, 2'd3}, t0, 0, 4);
    in_valid[0] = 1'b1;
    in_data[0]  = 4'b1111;
    for (int k = 1; k < 8; k++) begin
      cyc(1);
      chk("busy_mux_d_kept", int'(mux_d[0]), 0);
    end
    chk("busy_in_ready", int'(in_ready[0]), 0);
    cyc(1);
    chk("idle_in_ready", int'(in_ready[0]), 1);
    cyc(1);
    t1 = edge_n;
    in_valid[0] = 1'b0;
    chk("next_word_mux_d", int'(mux_d[0]), 4'b1111);
    push_word(0, 4'b1111, {2'd0, 2'd1, 2'd2, 2'd3}, t1, 0, 4);
    wait_idle(0);

    // Reset asserted while the third bit of 0110 is presented
    send(0, 4'b0110, t0);
    push_word(0, 4'b0110, {2'd0, 2'd1, 2'd2, 2'd3}, t0, 0, 2);
    cyc(5);
    chk("pre_rst_valid", int'(ser_valid[0]), 1);
    rst_n[0] = 1'b0;
    #1;
    chk_reset_vals(0);
    chk("rst_bits_seen", sb.size(), 0);
    cyc(2);
    rst_n[0] = 1'b1;
    cyc(1);
    send(0, 4'b1001, t0);
    push_word(0, 4'b1001, {2'd0, 2'd1, 2'd2, 2'd3}, t0, 0, 4);
    wait_idle(0);

    // GAP=2: ser_valid rises at E1,E5,E9,E13; last handshake at E14
    send(2, 4'b1100, t0);
    push_word(2, 4'b0011, {2'd0, 2'd1, 2'd2, 2'd3}, t0, 2, 4);
    cyc(4);
    chk("gap_valid_E4", int'(ser_valid[2]), 0);
    cyc(1);
    chk("gap_valid_E5", int'(ser_valid[2]), 1);
    cyc(8);
    chk("gap_valid_E13", int'(ser_valid[2]), 1);
    chk("gap_in_ready_E13", int'(in_ready[2]), 0);
    cyc(1);
    chk("gap_in_ready_E14", int'(in_ready[2]), 1);
    wait_idle(2);

    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux4_serializer_ctrl.md
Name: mux4_serializer_ctrl

Overview:
Upstream sequencer for the 4:1 bit-select mux (mux4). It accepts a 4-bit word over a valid/ready handshake, drives the mux data and select lines, and steps the select through all four positions. It samples the mux output each step and presents it as a serial bit stream with valid/ready/last. Sits between a parallel word source and a 1-bit serial consumer, with mux4 instantiated alongside it.

Parameters:
MSB_FIRST, 0, 0: select order 0,1,2,3 (D[0] first); 1: order 3,2,1,0.
GAP, 0, idle cycles inserted after each accepted bit before driving the next select; range 0..15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  4  upstream word
in_ready  output  1  block can accept a word
mux_d  output  4  registered word to mux D
mux_s  output  2  registered select to mux S
mux_a  input  1  mux output A; combinational function of mux_d/mux_s
ser_valid  output  1  serial bit valid
ser_bit  output  1  serial bit
ser_last  output  1  marks 4th bit of word
ser_ready  input  1  downstream accepts bit
busy  output  1  word in flight (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state=IDLE, mux_d=0, mux_s=0, ser_valid=0, ser_bit=0, ser_last=0, busy=0, in_ready=1, bit index=0, gap counter=0.
- Reset mid-operation: word discarded, all outputs return to reset values immediately; no partial stream completion.
- FSM states: IDLE, DRIVE, HOLD, WAIT.
- IDLE: in_ready=1. At an edge with in_valid=1: mux_d<=in_data, mux_s<=first select (0, or 3 if MSB_FIRST), index<=0, next DRIVE. in_valid=0 -> remain IDLE.
- in_ready=0 in every other state; in_valid/in_data ignored there.
- DRIVE (one cycle): at next edge ser_bit<=mux_a, ser_valid<=1, ser_last<=(index==3), next HOLD.
- HOLD: ser_valid, ser_bit, ser_last held stable until ser_valid&&ser_ready at an edge. At that edge: ser_valid<=0, ser_last<=0.
  - index==3 -> next IDLE; mux_d/mux_s keep their last values.
  - else index++, mux_s steps (+1, or -1 if MSB_FIRST); GAP==0 -> DRIVE; GAP>0 -> WAIT with counter=GAP.
- WAIT: counter decrements each cycle; leave for DRIVE on the edge where counter==1.
- mux_d and mux_s change only on an accept edge or a bit-handshake edge; both are stable for the full DRIVE cycle.
- Timing, GAP=0, ser_ready tied 1, accept at edge E0: ser_valid rises at E1, E3, E5, E7; handshakes at E2, E4, E6, E8; in_ready=1 from E8. Throughput: 1 bit per 2 cycles, 8 cycles per word.
- GAP=g adds g cycles per inter-bit step: 3g per word.
- ser_ready may be held high before ser_valid rises; this does not shorten any phase. ser_ready low stalls indefinitely in HOLD with no data change.
- busy = (state != IDLE); in_ready = !busy.

Test Plan:
- MSB_FIRST=0, GAP=0, ser_ready=1, in_data=4'b0111 accepted at E0 -> ser_bit 1,1,1,0 at E1/E3/E5/E7; mux_s 0,1,2,3; ser_last only with 4th bit; in_ready=1 after E8.
- MSB_FIRST=1, in_data=4'b0111 -> bits 0,1,1,1; mux_s 3,2,1,0; ser_last with final bit.
- Backpressure: in_data=4'b1010, ser_ready=0 for 5 cycles on 2nd bit -> ser_valid/ser_bit=1/mux_s=1 held stable; stream resumes 1 cycle after ser_ready rises; bits 0,1,0,1 with no loss or duplication.
- in_valid=1 with in_data=4'b1111 while busy -> ignored; current word 4'b0000 emits 0,0,0,0; next word accepted only in IDLE.
- rst_n low during 3rd bit -> all outputs at reset values asynchronously; after release, new word 4'b1001 streams 1,0,0,1 correctly.
- GAP=2, ser_ready=1, accept at E0 -> ser_valid rises at E1, E5, E9, E13; word complete at E14.
